// File: rtl/turnstile_controller.sv
// Coin/card turnstile: round-robin payment arbiter, credit counter, gate FSM.
// Optional idle auto-close when GATE_TIMEOUT_EN is defined.
module turnstile_controller #(
  parameter int CREDIT_W       = 4,
  parameter int PASS_W         = 16,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          pay_req,
  output logic [1:0]          pay_gnt,
  input  logic                turn,
  output logic                gate_open,
  output logic [CREDIT_W-1:0] credit,
  output logic [PASS_W-1:0]   pass_count,
  output logic                alarm,
  output logic                timeout
);

  typedef enum logic {
    CLOSED = 1'b0,
    OPENED = 1'b1
  } state_e;

  localparam logic [CREDIT_W-1:0] CMAX = '1;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic                alarm_q, alarm_d;
  logic                last_q, last_d;
  logic                consume;
  logic                allow;
  logic                granted;

`ifdef GATE_TIMEOUT_EN
  localparam logic [15:0] TLIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] idle_q, idle_d;
  logic        tout_q, tout_d;
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
`endif

  // last_q=1 means card was granted most recently, so coin is favoured
  always_comb begin
    consume = (state_q == CLOSED) && (credit_q != '0);
    allow   = !rst && ((credit_q != CMAX) || consume);
    pay_gnt = 2'b00;
    if (allow) begin
      case (pay_req)
        2'b01:   pay_gnt = 2'b01;
        2'b10:   pay_gnt = 2'b10;
        2'b11:   pay_gnt = last_q ? 2'b01 : 2'b10;
        default: pay_gnt = 2'b00;
      endcase
    end
    granted = |pay_gnt;
  end

  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    alarm_d  = 1'b0;
    credit_d = credit_q;
    last_d   = last_q;
`ifdef GATE_TIMEOUT_EN
    idle_d   = idle_q;
    tout_d   = 1'b0;
`endif
    if (granted && !consume) begin
      credit_d = credit_q + CREDIT_W'(1);
    end else if (!granted && consume) begin
      credit_d = credit_q - CREDIT_W'(1);
    end
    if (pay_gnt[0]) begin
      last_d = 1'b0;
    end else if (pay_gnt[1]) begin
      last_d = 1'b1;
    end
    case (state_q)
      CLOSED: begin
        alarm_d = turn;
        if (consume) begin
          state_d = OPENED;
        end
`ifdef GATE_TIMEOUT_EN
        idle_d = '0;
`endif
      end
      OPENED: begin
        if (turn) begin
          state_d = CLOSED;
          pass_d  = pass_q + PASS_W'(1);
`ifdef GATE_TIMEOUT_EN
          idle_d  = '0;
        end else if (idle_q + 16'd1 == TLIM) begin
          state_d = CLOSED;
          tout_d  = 1'b1;
          idle_d  = '0;
        end else begin
          idle_d  = idle_q + 16'd1;
`endif
        end
      end
      default: state_d = CLOSED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CLOSED;
      credit_q <= '0;
      pass_q   <= '0;
      alarm_q  <= 1'b0;
      last_q   <= 1'b1;
`ifdef GATE_TIMEOUT_EN
      idle_q   <= '0;
      tout_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      pass_q   <= pass_d;
      alarm_q  <= alarm_d;
      last_q   <= last_d;
`ifdef GATE_TIMEOUT_EN
      idle_q   <= idle_d;
      tout_q   <= tout_d;
`endif
    end
  end

  assign gate_open  = (state_q == OPENED);
  assign credit     = credit_q;
  assign pass_count = pass_q;
  assign alarm      = alarm_q;
`ifdef GATE_TIMEOUT_EN
  assign timeout    = tout_q;
`else
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_turnstile_controller.sv
// Bench for turnstile_controller: directed vector table, hand sequences,
// and random traffic against an integer reference model.
module tb_turnstile_controller;

  localparam int CW   = 2;
  localparam int PW   = 4;
  localparam int TC   = 5;
  localparam int CMAX = (1 << CW) - 1;
  localparam int PMOD = 1 << PW;
`ifdef GATE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [1:0]    pay_req;
  logic [1:0]    pay_gnt;
  logic          turn;
  logic          gate_open;
  logic [CW-1:0] credit;
  logic [PW-1:0] pass_count;
  logic          alarm;
  logic          timeout;

  turnstile_controller #(
    .CREDIT_W(CW),
    .PASS_W(PW),
    .TIMEOUT_CYCLES(TC)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .pay_req(pay_req),
    .pay_gnt(pay_gnt),
    .turn(turn),
    .gate_open(gate_open),
    .credit(credit),
    .pass_count(pass_count),
    .alarm(alarm),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // reference model state, plain integers
  int m_open, m_credit, m_pass, m_alarm, m_tout, m_last, m_idle;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_open = 0; m_credit = 0; m_pass = 0;
    m_alarm = 0; m_tout = 0; m_last = 1; m_idle = 0;
  endtask

  function automatic int m_gnt(input logic [1:0] req);
    bit cons;
    cons = (m_open == 0) && (m_credit > 0);
    if (m_credit >= CMAX && !cons) return 0;
    if (req == 2'b11) return (m_last == 1) ? 1 : 2;
    return int'(req);
  endfunction

  task automatic m_step(input logic r, input logic [1:0] req, input logic t);
    int g;
    bit cons;
    if (r) begin
      m_reset();
      return;
    end
    cons = (m_open == 0) && (m_credit > 0);
    g = m_gnt(req);
    m_alarm = (m_open == 0) && t;
    m_tout = 0;
    if (g != 0) m_last = (g == 2) ? 1 : 0;
    m_credit = m_credit + ((g != 0) ? 1 : 0) - (cons ? 1 : 0);
    if (m_open != 0) begin
      if (t) begin
        m_open = 0;
        m_pass = (m_pass + 1) % PMOD;
        m_idle = 0;
      end else if (TO_EN) begin
        m_idle++;
        if (m_idle == TC) begin
          m_open = 0;
          m_tout = 1;
          m_idle = 0;
        end
      end
    end else begin
      m_idle = 0;
      if (cons) m_open = 1;
    end
  endtask

  // one clock: drive, compare against model at negedge, advance model
  task automatic cyc(input logic r, input logic [1:0] req, input logic t);
    rst = r; pay_req = req; turn = t;
    if (r) m_reset();
    @(negedge clk);
    chk("gnt", 32'(pay_gnt), r ? 32'd0 : 32'(m_gnt(req)));
    chk("gate_open", 32'(gate_open), 32'(m_open));
    chk("credit", 32'(credit), 32'(m_credit));
    chk("pass_count", 32'(pass_count), 32'(m_pass));
    chk("alarm", 32'(alarm), 32'(m_alarm));
    chk("timeout", 32'(timeout), 32'(m_tout));
    @(posedge clk);
    m_step(r, req, t);
    #1;
  endtask

  typedef struct {
    logic       r;
    logic [1:0] req;
    logic       t;
    logic [1:0] gnt;
    logic       open;
    logic [1:0] cr;
    logic [3:0] pass;
    logic       alm;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int n_open;
    int n_tout;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1; pay_req = 2'b00; turn = 1'b0;
    m_reset();

    tbl[0]  = '{1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[1]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'd1, 4'd0, 1'b0};
    tbl[2]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'd0, 4'd0, 1'b0};
    tbl[3]  = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 2'd0, 4'd0, 1'b0};
    tbl[4]  = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'd0, 4'd1, 1'b0};
    tbl[5]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0, 4'd1, 1'b1};
    tbl[6]  = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[7]  = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[8]  = '{1'b0, 2'b11, 1'b0, 2'b10, 1'b0, 2'd1, 4'd0, 1'b0};
    tbl[9]  = '{1'b0, 2'b11, 1'b0, 2'b01, 1'b1, 2'd1, 4'd0, 1'b0};
    tbl[10] = '{1'b0, 2'b11, 1'b0, 2'b10, 1'b1, 2'd2, 4'd0, 1'b0};
    tbl[11] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'd3, 4'd0, 1'b0};
    tbl[12] = '{1'b0, 2'b01, 1'b0, 2'b00, 1'b1, 2'd3, 4'd0, 1'b0};
    tbl[13] = '{1'b0, 2'b10, 1'b1, 2'b00, 1'b1, 2'd3, 4'd0, 1'b0};
    tbl[14] = '{1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 2'd3, 4'd1, 1'b0};
    tbl[15] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'd3, 4'd1, 1'b0};

    @(negedge clk);
    chk("rst gnt", 32'(pay_gnt), 32'd0);
    chk("rst gate_open", 32'(gate_open), 32'd0);
    chk("rst credit", 32'(credit), 32'd0);
    chk("rst pass_count", 32'(pass_count), 32'd0);
    chk("rst alarm", 32'(alarm), 32'd0);
    chk("rst timeout", 32'(timeout), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].r; pay_req = tbl[i].req; turn = tbl[i].t;
      @(negedge clk);
      chk($sformatf("vec%0d gnt", i), 32'(pay_gnt), 32'(tbl[i].gnt));
      chk($sformatf("vec%0d open", i), 32'(gate_open), 32'(tbl[i].open));
      chk($sformatf("vec%0d credit", i), 32'(credit), 32'(tbl[i].cr));
      chk($sformatf("vec%0d pass", i), 32'(pass_count), 32'(tbl[i].pass));
      chk($sformatf("vec%0d alarm", i), 32'(alarm), 32'(tbl[i].alm));
      @(posedge clk);
      m_step(tbl[i].r, tbl[i].req, tbl[i].t);
      #1;
    end

    // async reset while open with two credits banked
    cyc(1'b1, 2'b00, 1'b0);
    cyc(1'b0, 2'b01, 1'b0);
    cyc(1'b0, 2'b01, 1'b0);
    cyc(1'b0, 2'b01, 1'b0);
    chk("pre-rst open", 32'(gate_open), 32'd1);
    chk("pre-rst credit", 32'(credit), 32'd2);
    pay_req = 2'b11;
    #2 rst = 1'b1;
    #1;
    chk("async rst open", 32'(gate_open), 32'd0);
    chk("async rst credit", 32'(credit), 32'd0);
    chk("async rst gnt", 32'(pay_gnt), 32'd0);
    m_reset();
    @(posedge clk);
    #1;

    // open once and leave the gate idle
    cyc(1'b0, 2'b01, 1'b0);
    cyc(1'b0, 2'b00, 1'b0);
    n_open = 0;
    n_tout = 0;
    for (int k = 0; k < TC + 4; k++) begin
      if (gate_open) n_open++;
      if (timeout) n_tout++;
      cyc(1'b0, 2'b00, 1'b0);
    end
    chk("idle open cycles", 32'(n_open), TO_EN ? 32'(TC) : 32'(TC + 4));
    chk("timeout pulses", 32'(n_tout), TO_EN ? 32'd1 : 32'd0);
    chk("idle pass_count", 32'(pass_count), 32'd0);

    // random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      logic r;
      logic [1:0] rq;
      logic t;
      r  = ($urandom_range(0, 299) == 0);
      rq = 2'($urandom_range(0, 3));
      t  = ($urandom_range(0, 3) == 0);
      cyc(r, rq, t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
